// File: rtl/mul14_seq_ctrl.sv
// rtl/mul14_seq_ctrl.sv - 14x14 unsigned multiply sequenced over one shared 7x7 multiplier
//
// Computes out_p = in_a * in_b in four passes through an external 7x7
// multiplier that has MUL_LAT register stages. Each pass holds mul_a/mul_b
// for MUL_LAT+1 cycles and adds the returned partial product into a 28-bit
// accumulator at its 0/7/14-bit weight.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   in_valid/in_ready operand handshake (in_ready high only when idle)
//   in_a, in_b        14-bit unsigned operands
//   mul_a, mul_b      7-bit operands to the shared multiplier
//   mul_en            high for every cycle of a pass
//   mul_p             14-bit product from the shared multiplier
//   out_valid/out_ready result handshake
//   out_p             28-bit product (meaningful when out_valid)
//   busy              high whenever not idle

module mul14_seq_ctrl #(
    parameter int MUL_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [13:0] in_a,
    input  logic [13:0] in_b,
    output logic [6:0]  mul_a,
    output logic [6:0]  mul_b,
    output logic        mul_en,
    input  logic [13:0] mul_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [27:0] out_p,
    output logic        busy
);

    localparam int WCW = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [13:0]     r_op_a;
    logic [13:0]     r_op_b;
    logic [1:0]      r_step;
    logic [WCW-1:0]  r_wcnt;
    logic [27:0]     r_acc;

    logic            w_last;
    logic [6:0]      w_a_sel;
    logic [6:0]      w_b_sel;
    logic [27:0]     w_term;

    // The last cycle of a pass is the one on which mul_p is valid.
    assign w_last = (r_wcnt == WCW'(MUL_LAT));

    // step[0] selects the high half of A, step[1] the high half of B:
    // 0: aL*bL, 1: aH*bL, 2: aL*bH, 3: aH*bH.
    assign w_a_sel = r_step[0] ? r_op_a[13:7] : r_op_a[6:0];
    assign w_b_sel = r_step[1] ? r_op_b[13:7] : r_op_b[6:0];

    always_comb begin
        w_term = '0;
        case (r_step)
            2'd0:    w_term = {14'd0, mul_p};
            2'd3:    w_term = {mul_p, 14'd0};
            default: w_term = {7'd0, mul_p, 7'd0};
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        mul_en      = 1'b0;
        mul_a       = 7'd0;
        mul_b       = 7'd0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                mul_en = 1'b1;
                mul_a  = w_a_sel;
                mul_b  = w_b_sel;
                if (w_last && (r_step == 2'd3)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_step  <= '0;
            r_wcnt  <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op_a <= in_a;
                        r_op_b <= in_b;
                        r_acc  <= '0;
                        r_step <= '0;
                        r_wcnt <= '0;
                    end
                end
                S_RUN: begin
                    if (w_last) begin
                        r_acc  <= r_acc + w_term;
                        r_wcnt <= '0;
                        r_step <= r_step + 2'd1;
                    end else begin
                        r_wcnt <= r_wcnt + WCW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_p = r_acc;

endmodule

// File: tb/tb_mul14_seq_ctrl.sv
// tb/tb_mul14_seq_ctrl.sv - self-checking bench for mul14_seq_ctrl at MUL_LAT 0..3

module tb_mul14_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        lv_in_valid  [4];
    logic        lv_in_ready  [4];
    logic [13:0] lv_in_a      [4];
    logic [13:0] lv_in_b      [4];
    logic [6:0]  lv_mul_a     [4];
    logic [6:0]  lv_mul_b     [4];
    logic        lv_mul_en    [4];
    logic [13:0] lv_mul_p     [4];
    logic        lv_out_valid [4];
    logic        lv_out_ready [4];
    logic [27:0] lv_out_p     [4];
    logic        lv_busy      [4];

    int n_checks = 0;
    int n_errors = 0;

    // Lane g runs a DUT with MUL_LAT=g against a g-stage 7x7 multiplier.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [13:0] w_prod;
        assign w_prod = {7'd0, lv_mul_a[g]} * {7'd0, lv_mul_b[g]};
        if (g == 0) begin : g_comb
            assign lv_mul_p[g] = w_prod;
        end else begin : g_reg
            logic [13:0] r_pipe [g];
            always_ff @(posedge clk) begin
                r_pipe[0] <= w_prod;
                for (int i = 1; i < g; i++) r_pipe[i] <= r_pipe[i-1];
            end
            assign lv_mul_p[g] = r_pipe[g-1];
        end

        mul14_seq_ctrl #(.MUL_LAT(g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (lv_in_valid[g]),
            .in_ready  (lv_in_ready[g]),
            .in_a      (lv_in_a[g]),
            .in_b      (lv_in_b[g]),
            .mul_a     (lv_mul_a[g]),
            .mul_b     (lv_mul_b[g]),
            .mul_en    (lv_mul_en[g]),
            .mul_p     (lv_mul_p[g]),
            .out_valid (lv_out_valid[g]),
            .out_ready (lv_out_ready[g]),
            .out_p     (lv_out_p[g]),
            .busy      (lv_busy[g])
        );
    end

    task automatic check(input string name, input int l, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s lane%0d t=%0t got=0x%0h exp=0x%0h", name, l, $time, got, exp);
        end
    endtask

    // Model: mk = cycles since acceptance (0 = idle). Cycles 1..4*(L+1) are
    // the four passes; after that the result is presented until taken.
    int          mk [4];
    logic [13:0] ma [4];
    logic [13:0] mb [4];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < 4; l++) mk[l] <= 0;
        end else begin
            for (int l = 0; l < 4; l++) begin
                if (mk[l] == 0) begin
                    if (lv_in_valid[l]) begin
                        mk[l] <= 1;
                        ma[l] <= lv_in_a[l];
                        mb[l] <= lv_in_b[l];
                    end
                end else if (mk[l] <= 4 * (l + 1)) begin
                    mk[l] <= mk[l] + 1;
                end else if (lv_out_ready[l]) begin
                    mk[l] <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int l = 0; l < 4; l++) begin
            int          pass;
            bit          run;
            bit          done;
            logic [6:0]  ea;
            logic [6:0]  eb;
            logic [27:0] ep;
            run  = (mk[l] >= 1) && (mk[l] <= 4 * (l + 1));
            done = (mk[l] > 4 * (l + 1));
            pass = run ? (mk[l] - 1) / (l + 1) : 0;
            ea   = 7'd0;
            eb   = 7'd0;
            if (run) begin
                ea = (pass == 1 || pass == 3) ? ma[l][13:7] : ma[l][6:0];
                eb = (pass >= 2) ? mb[l][13:7] : mb[l][6:0];
            end
            ep = 28'(ma[l]) * 28'(mb[l]);
            check("in_ready",  l, 32'(lv_in_ready[l]),  32'(mk[l] == 0));
            check("busy",      l, 32'(lv_busy[l]),      32'(mk[l] != 0));
            check("mul_en",    l, 32'(lv_mul_en[l]),    32'(run));
            check("out_valid", l, 32'(lv_out_valid[l]), 32'(done));
            check("mul_a",     l, 32'(lv_mul_a[l]),     32'(ea));
            check("mul_b",     l, 32'(lv_mul_b[l]),     32'(eb));
            if (done) check("out_p", l, 32'(lv_out_p[l]), 32'(ep));
        end
    end

    // Offer operands and return on the negedge of the first cycle after acceptance.
    task automatic start(input int l, input logic [13:0] a, input logic [13:0] b);
        int n;
        @(negedge clk);
        lv_in_a[l]     = a;
        lv_in_b[l]     = b;
        lv_in_valid[l] = 1'b1;
        n = 0;
        while (!lv_in_ready[l] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!lv_in_ready[l]) check("accept_timeout", l, 32'd0, 32'd1);
        @(negedge clk);
        lv_in_valid[l] = 1'b0;
    endtask

    // Called right after start(): lat is the cycle offset from acceptance at
    // which out_valid is first seen; en_cnt counts mul_en cycles on the way.
    task automatic wait_valid(input int l, output int lat, output int en_cnt, output logic [27:0] p);
        lat    = 1;
        en_cnt = 0;
        while (!lv_out_valid[l] && lat < 200) begin
            if (lv_mul_en[l]) en_cnt++;
            @(negedge clk);
            lat++;
        end
        if (!lv_out_valid[l]) check("valid_timeout", l, 32'd0, 32'd1);
        p = lv_out_p[l];
    endtask

    task automatic run_rand(input int l, input logic [13:0] a, input logic [13:0] b);
        int n;
        bit taken;
        start(l, a, b);
        taken = 1'b0;
        n = 0;
        while (!taken && n < 300) begin
            lv_out_ready[l] = 1'($urandom_range(0, 1));
            if (lv_out_valid[l] && lv_out_ready[l]) begin
                check("rand_p", l, 32'(lv_out_p[l]), 32'(28'(a) * 28'(b)));
                taken = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        lv_out_ready[l] = 1'b0;
        if (!taken) check("rand_timeout", l, 32'd0, 32'd1);
    endtask

    int          lat;
    int          en_cnt;
    logic [27:0] p;

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int l = 0; l < 4; l++) begin
            lv_in_valid[l]  = 1'b0;
            lv_in_a[l]      = '0;
            lv_in_b[l]      = '0;
            lv_out_ready[l] = 1'b0;
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        for (int l = 0; l < 4; l++) begin
            check("rst_out_p",     l, 32'(lv_out_p[l]),     32'd0);
            check("rst_in_ready",  l, 32'(lv_in_ready[l]),  32'd1);
            check("rst_mul_en",    l, 32'(lv_mul_en[l]),    32'd0);
            check("rst_out_valid", l, 32'(lv_out_valid[l]), 32'd0);
            check("rst_busy",      l, 32'(lv_busy[l]),      32'd0);
        end

        // All-ones operands, MUL_LAT=0.
        lv_out_ready[0] = 1'b1;
        start(0, 14'h3FFF, 14'h3FFF);
        check("t1_mul_a", 0, 32'(lv_mul_a[0]), 32'h7F);
        wait_valid(0, lat, en_cnt, p);
        check("t1_latency", 0, 32'(lat), 32'd5);
        check("t1_en_cycles", 0, 32'(en_cnt), 32'd4);
        check("t1_out_p", 0, 32'(p), 32'h0FFF8001);
        @(negedge clk);
        check("t1_back_idle", 0, 32'(lv_in_ready[0]), 32'd1);

        // MUL_LAT=2: 3-cycle passes.
        lv_out_ready[2] = 1'b1;
        start(2, 14'h0081, 14'h0081);
        wait_valid(2, lat, en_cnt, p);
        check("t2_latency", 2, 32'(lat), 32'd13);
        check("t2_en_cycles", 2, 32'(en_cnt), 32'd12);
        check("t2_out_p", 2, 32'(p), 32'h4101);
        @(negedge clk);

        // Back-pressure on MUL_LAT=1 with a second operand pair waiting.
        lv_out_ready[1] = 1'b0;
        start(1, 14'h2000, 14'h0003);
        wait_valid(1, lat, en_cnt, p);
        check("t3_latency", 1, 32'(lat), 32'd9);
        lv_in_a[1]     = 14'd5;
        lv_in_b[1]     = 14'd9;
        lv_in_valid[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_valid", 1, 32'(lv_out_valid[1]), 32'd1);
            check("t3_hold_p",     1, 32'(lv_out_p[1]),     32'h6000);
            check("t3_in_ready",   1, 32'(lv_in_ready[1]),  32'd0);
            @(negedge clk);
        end
        lv_out_ready[1] = 1'b1;
        @(negedge clk);
        lv_out_ready[1] = 1'b0;
        check("t3_idle_ready", 1, 32'(lv_in_ready[1]), 32'd1);
        check("t3_idle_valid", 1, 32'(lv_out_valid[1]), 32'd0);
        @(negedge clk);
        lv_in_valid[1] = 1'b0;
        check("t3_second_busy", 1, 32'(lv_busy[1]), 32'd1);
        wait_valid(1, lat, en_cnt, p);
        check("t3_second_p", 1, 32'(p), 32'h2D);
        lv_out_ready[1] = 1'b1;
        @(negedge clk);
        lv_out_ready[1] = 1'b0;

        // Reset during step 2 of MUL_LAT=0.
        lv_out_ready[0] = 1'b1;
        start(0, 14'h1234, 14'h0567);
        @(negedge clk);
        @(negedge clk);
        check("t4_step2_a", 0, 32'(lv_mul_a[0]), 32'h34);
        check("t4_step2_b", 0, 32'(lv_mul_b[0]), 32'h0A);
        #2 rst = 1'b1;
        #1;
        check("t4_rst_busy",   0, 32'(lv_busy[0]),     32'd0);
        check("t4_rst_mul_en", 0, 32'(lv_mul_en[0]),   32'd0);
        check("t4_rst_ready",  0, 32'(lv_in_ready[0]), 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_no_valid", 0, 32'(lv_out_valid[0]), 32'd0);
        end
        start(0, 14'h0005, 14'h0007);
        wait_valid(0, lat, en_cnt, p);
        check("t4_latency", 0, 32'(lat), 32'd5);
        check("t4_out_p", 0, 32'(p), 32'h23);
        @(negedge clk);
        lv_out_ready[0] = 1'b0;

        // Random operands over MUL_LAT 0, 1, 3 with random out_ready.
        for (int i = 0; i < 1000; i++) begin
            int          l;
            logic [13:0] a;
            logic [13:0] b;
            l = (i % 3 == 2) ? 3 : (i % 3);
            a = 14'($urandom_range(0, 16383));
            b = 14'($urandom_range(0, 16383));
            if (i % 97 == 0) a = 14'd0;
            if (i % 89 == 0) b = 14'd0;
            if (i == 500) begin
                a = 14'h3FFF;
                b = 14'h3FFF;
            end
            run_rand(l, a, b);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
